// File: rtl/pcounter_mc_if.sv
// -----------------------------------------------------------------------------
// pcounter_mc_if
// Configuration bus for the multi-channel programmable counter bank.
//
// Signals:
//   enable  access strobe, one cycle per access
//   rd_wr   1 = write, 0 = read (qualified by enable)
//   addr    {channel, reg[1:0]}
//   wdata   write data
//   rdata   registered read data (held after rvalid drops)
//   rvalid  one-cycle pulse qualifying rdata, one cycle after a read strobe
//
// Modports: master drives the access, slave is the counter bank.
// -----------------------------------------------------------------------------
interface pcounter_mc_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 10
);
    // Channel field plus two register-select bits, never narrower than 3 bits.
    localparam int ADDR_W = (N_CH <= 2) ? 3 : $clog2(N_CH) + 2;

    logic              enable;
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;

    modport master (
        output enable, rd_wr, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  enable, rd_wr, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/pcounter_mc.sv
// -----------------------------------------------------------------------------
// pcounter_mc
// Bank of N_CH programmable WIDTH-bit counters, each with up/down direction,
// one-shot or auto-reload mode, a one-cycle terminal-count pulse, a sticky
// status flag and an interrupt enable. Programmed and read back over the
// cfg bus.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   cfg       pcounter_mc_if.slave configuration bus (registered read-back)
//   tc_pulse  per-channel terminal-count pulse, high the cycle after the tick
//   irq       OR over channels of (STATUS.tc & CTRL.ie)
//
// Register map per channel (addr = {channel, reg}):
//   0 CTRL   bit0 en, bit1 dir (1 = down), bit2 reload, bit3 ie, [7:4] psc
//   1 LOAD
//   2 COUNT  live value; a write forces it
//   3 STATUS bit0 tc, sticky, write 1 to clear
//
// Optional feature macro: PCOUNTER_PRESCALE_EN
//   defined   - per-channel 4-bit prescaler, one tick every psc+1 clocks,
//               CTRL[7:4] read/write
//   undefined - every enabled clock is a tick, CTRL[7:4] ignored, reads 0
// -----------------------------------------------------------------------------
module pcounter_mc #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    pcounter_mc_if.slave    cfg,
    output logic [N_CH-1:0] tc_pulse,
    output logic            irq
);
    localparam int ADDR_W = (N_CH <= 2) ? 3 : $clog2(N_CH) + 2;
    localparam int CH_W   = ADDR_W - 2;

    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]       REG_CTRL   = 2'd0;
    localparam logic [1:0]       REG_LOAD   = 2'd1;
    localparam logic [1:0]       REG_COUNT  = 2'd2;
    localparam logic [1:0]       REG_STATUS = 2'd3;

    // Per-channel state
    logic [N_CH-1:0]  en_q;
    logic [N_CH-1:0]  dir_q;
    logic [N_CH-1:0]  reload_q;
    logic [N_CH-1:0]  ie_q;
    logic [N_CH-1:0]  status_q;
    logic [WIDTH-1:0] load_q  [N_CH];
    logic [WIDTH-1:0] count_q [N_CH];
`ifdef PCOUNTER_PRESCALE_EN
    logic [3:0]       psc_q   [N_CH];
    logic [3:0]       pcnt_q  [N_CH];
`endif

    // Access decode
    logic [CH_W-1:0]  sel_ch;
    logic [1:0]       sel_reg;
    logic             ch_valid;
    logic             wr_acc;
    logic             rd_acc;

    logic [N_CH-1:0]  wr_ctrl;
    logic [N_CH-1:0]  wr_load;
    logic [N_CH-1:0]  wr_count;
    logic [N_CH-1:0]  wr_status;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  term_evt;
    logic [WIDTH-1:0] ctrl_word [N_CH];
    logic [WIDTH-1:0] rd_val;

    // Terminal value: LOAD when counting up, zero when counting down.
    function automatic logic [WIDTH-1:0] term_val(
        input logic [WIDTH-1:0] load,
        input logic             dir
    );
        return dir ? '0 : load;
    endfunction

    // COUNT after a tick that was not overridden by a cfg write.
    function automatic logic [WIDTH-1:0] next_count(
        input logic [WIDTH-1:0] cnt,
        input logic [WIDTH-1:0] load,
        input logic             dir,
        input logic             reload
    );
        logic [WIDTH-1:0] nxt;
        if (cnt == term_val(load, dir)) begin
            if (!reload)  nxt = cnt;          // one-shot parks on the terminal value
            else if (dir) nxt = load;
            else          nxt = '0;
        end else if (dir) begin
            nxt = cnt - ONE;
        end else begin
            nxt = cnt + ONE;
        end
        return nxt;
    endfunction

    assign sel_ch   = cfg.addr[ADDR_W-1:2];
    assign sel_reg  = cfg.addr[1:0];
    assign ch_valid = (32'(sel_ch) < N_CH);
    // Writes to non-existent channels are dropped; reads still answer (with 0).
    assign wr_acc   = cfg.enable & cfg.rd_wr & ch_valid;
    assign rd_acc   = cfg.enable & ~cfg.rd_wr;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_ctrl[i]   = wr_acc && (32'(sel_ch) == i) && (sel_reg == REG_CTRL);
            wr_load[i]   = wr_acc && (32'(sel_ch) == i) && (sel_reg == REG_LOAD);
            wr_count[i]  = wr_acc && (32'(sel_ch) == i) && (sel_reg == REG_COUNT);
            wr_status[i] = wr_acc && (32'(sel_ch) == i) && (sel_reg == REG_STATUS);
`ifdef PCOUNTER_PRESCALE_EN
            // >= rather than == so a psc lowered mid-period cannot strand the prescaler.
            tick[i]      = en_q[i] && (pcnt_q[i] >= psc_q[i]);
            ctrl_word[i] = WIDTH'({psc_q[i], ie_q[i], reload_q[i], dir_q[i], en_q[i]});
`else
            tick[i]      = en_q[i];
            ctrl_word[i] = WIDTH'({4'b0000, ie_q[i], reload_q[i], dir_q[i], en_q[i]});
`endif
            // A COUNT write on the tick edge suppresses the terminal event.
            term_evt[i]  = tick[i] && !wr_count[i] &&
                           (count_q[i] == term_val(load_q[i], dir_q[i]));
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (32'(sel_ch) == i) begin
                case (sel_reg)
                    REG_CTRL:   rd_val = ctrl_word[i];
                    REG_LOAD:   rd_val = load_q[i];
                    REG_COUNT:  rd_val = count_q[i];
                    default:    rd_val = {{(WIDTH-1){1'b0}}, status_q[i]};
                endcase
            end
        end
    end

    // Channel state update on the clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= '0;
            dir_q    <= '0;
            reload_q <= '0;
            ie_q     <= '0;
            status_q <= '0;
            tc_pulse <= '0;
            for (int i = 0; i < N_CH; i++) begin
                load_q[i]  <= '0;
                count_q[i] <= '0;
`ifdef PCOUNTER_PRESCALE_EN
                psc_q[i]   <= '0;
                pcnt_q[i]  <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                // A cfg write to CTRL beats the one-shot auto-disable.
                if (wr_ctrl[i]) begin
                    en_q[i]     <= cfg.wdata[0];
                    dir_q[i]    <= cfg.wdata[1];
                    reload_q[i] <= cfg.wdata[2];
                    ie_q[i]     <= cfg.wdata[3];
`ifdef PCOUNTER_PRESCALE_EN
                    psc_q[i]    <= cfg.wdata[7:4];
`endif
                end else if (term_evt[i] && !reload_q[i]) begin
                    en_q[i] <= 1'b0;
                end

                if (wr_load[i]) begin
                    load_q[i] <= cfg.wdata;
                end

                if (wr_count[i]) begin
                    count_q[i] <= cfg.wdata;
                end else if (tick[i]) begin
                    count_q[i] <= next_count(count_q[i], load_q[i], dir_q[i], reload_q[i]);
                end

                // A new terminal event beats a simultaneous write-1-to-clear.
                if (term_evt[i]) begin
                    status_q[i] <= 1'b1;
                end else if (wr_status[i] && cfg.wdata[0]) begin
                    status_q[i] <= 1'b0;
                end

                tc_pulse[i] <= term_evt[i];

`ifdef PCOUNTER_PRESCALE_EN
                if (!en_q[i] || wr_count[i] || tick[i]) begin
                    pcnt_q[i] <= '0;
                end else begin
                    pcnt_q[i] <= pcnt_q[i] + 4'd1;
                end
`endif
            end
        end
    end

    // Registered read-back; rdata holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg.rdata  <= '0;
            cfg.rvalid <= 1'b0;
        end else begin
            cfg.rvalid <= rd_acc;
            if (rd_acc) begin
                cfg.rdata <= rd_val;
            end
        end
    end

    assign irq = |(status_q & ie_q);

endmodule

// File: tb/tb_pcounter_mc.sv
// -----------------------------------------------------------------------------
// tb_pcounter_mc
// Directed scenarios followed by randomized cfg traffic on a 4-channel bank,
// checked every clock against a behavioural model of the counter rules. A
// second 3-channel instance exercises accesses to a non-existent channel.
// -----------------------------------------------------------------------------
module tb_pcounter_mc;
    localparam int N_CH  = 4;
    localparam int WIDTH = 10;
    localparam int MOD   = 1 << WIDTH;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] tc_pulse;
    logic            irq;
    logic [2:0]      tc3;
    logic            irq3;

    pcounter_mc_if #(.N_CH(4), .WIDTH(10)) cfg  ();
    pcounter_mc_if #(.N_CH(3), .WIDTH(10)) cfg3 ();

    pcounter_mc #(.N_CH(4), .WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg), .tc_pulse(tc_pulse), .irq(irq)
    );

    pcounter_mc #(.N_CH(3), .WIDTH(10)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg(cfg3), .tc_pulse(tc3), .irq(irq3)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int m_en  [N_CH];
    int m_dir [N_CH];
    int m_rel [N_CH];
    int m_ie  [N_CH];
    int m_psc [N_CH];
    int m_pc  [N_CH];
    int m_load[N_CH];
    int m_cnt [N_CH];
    int m_st  [N_CH];
    int m_tc  [N_CH];
    int m_rdata;
    int m_rvalid;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_en[c] = 0; m_dir[c] = 0; m_rel[c] = 0; m_ie[c] = 0; m_psc[c] = 0;
            m_pc[c] = 0; m_load[c] = 0; m_cnt[c] = 0; m_st[c] = 0; m_tc[c] = 0;
        end
        m_rdata  = 0;
        m_rvalid = 0;
    endtask

    function automatic int ctrl_val(input int c);
        int v;
        v = m_en[c] + 2 * m_dir[c] + 4 * m_rel[c] + 8 * m_ie[c];
`ifdef PCOUNTER_PRESCALE_EN
        v = v + 16 * m_psc[c];
`endif
        return v;
    endfunction

    function automatic int reg_val(input int c, input int r);
        if (c >= N_CH) return 0;
        case (r)
            0:       return ctrl_val(c);
            1:       return m_load[c];
            2:       return m_cnt[c];
            default: return m_st[c];
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs now on the bus.
    task automatic model_edge();
        int a, ch, rg, d, term, ncnt;
        bit wr, rd, wcnt, tk, evt;
        a  = int'(cfg.addr);
        ch = a / 4;
        rg = a % 4;
        d  = int'(cfg.wdata);
        wr = (cfg.enable === 1'b1) && (cfg.rd_wr === 1'b1) && (ch < N_CH);
        rd = (cfg.enable === 1'b1) && (cfg.rd_wr === 1'b0);
        if (rd) begin
            m_rvalid = 1;
            m_rdata  = reg_val(ch, rg);
        end else begin
            m_rvalid = 0;
        end
        for (int c = 0; c < N_CH; c++) begin
            wcnt = wr && (ch == c) && (rg == 2);
`ifdef PCOUNTER_PRESCALE_EN
            tk = (m_en[c] == 1) && (m_pc[c] >= m_psc[c]);
`else
            tk = (m_en[c] == 1);
`endif
            term = (m_dir[c] == 1) ? 0 : m_load[c];
            evt  = tk && !wcnt && (m_cnt[c] == term);
            if (wcnt)     ncnt = d;
            else if (evt) ncnt = (m_rel[c] == 0) ? m_cnt[c] : ((m_dir[c] == 1) ? m_load[c] : 0);
            else if (tk)  ncnt = (m_dir[c] == 1) ? (m_cnt[c] + MOD - 1) % MOD : (m_cnt[c] + 1) % MOD;
            else          ncnt = m_cnt[c];
            if (m_en[c] == 0 || wcnt || tk) m_pc[c] = 0;
            else                            m_pc[c] = m_pc[c] + 1;
            if (wr && ch == c && rg == 0) begin
                m_en[c]  = d % 2;
                m_dir[c] = (d / 2) % 2;
                m_rel[c] = (d / 4) % 2;
                m_ie[c]  = (d / 8) % 2;
                m_psc[c] = (d / 16) % 16;
            end else if (evt && m_rel[c] == 0) begin
                m_en[c] = 0;
            end
            if (wr && ch == c && rg == 1) m_load[c] = d;
            if (evt)                                      m_st[c] = 1;
            else if (wr && ch == c && rg == 3 && d % 2 == 1) m_st[c] = 0;
            m_cnt[c] = ncnt;
            m_tc[c]  = evt ? 1 : 0;
        end
    endtask

    task automatic step();
        logic [31:0] etc;
        logic [31:0] eirq;
        model_edge();
        @(posedge clk);
        #1;
        etc  = '0;
        eirq = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (m_tc[c] == 1) etc[c] = 1'b1;
            if (m_st[c] == 1 && m_ie[c] == 1) eirq = 32'd1;
        end
        check("tc_pulse", 32'(tc_pulse), etc);
        check("irq", 32'(irq), eirq);
        check("rvalid", 32'(cfg.rvalid), 32'(m_rvalid));
        check("rdata", 32'(cfg.rdata), 32'(m_rdata));
    endtask

    task automatic idle();
        cfg.enable = 1'b0;
        cfg.rd_wr  = 1'b0;
        cfg.addr   = '0;
        cfg.wdata  = '0;
    endtask

    task automatic wr(input int a, input int d);
        cfg.enable = 1'b1;
        cfg.rd_wr  = 1'b1;
        cfg.addr   = 4'(a);
        cfg.wdata  = 10'(d);
        step();
        idle();
    endtask

    task automatic rd_expect(input string tag, input int a, input int exp);
        cfg.enable = 1'b1;
        cfg.rd_wr  = 1'b0;
        cfg.addr   = 4'(a);
        step();
        idle();
        check({tag, "_rvalid"}, 32'(cfg.rvalid), 32'd1);
        check(tag, 32'(cfg.rdata), 32'(exp));
    endtask

    task automatic acc3(input bit w, input int a, input int d);
        cfg3.enable = 1'b1;
        cfg3.rd_wr  = w;
        cfg3.addr   = 4'(a);
        cfg3.wdata  = 10'(d);
        step();
        cfg3.enable = 1'b0;
    endtask

    initial begin
        int n;
        int r;
        rst_n       = 1'b0;
        idle();
        cfg3.enable = 1'b0;
        cfg3.rd_wr  = 1'b0;
        cfg3.addr   = '0;
        cfg3.wdata  = '0;
        model_reset();
        #12;
        check("rst_tc_pulse", 32'(tc_pulse), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rvalid", 32'(cfg.rvalid), 32'd0);
        check("rst_rdata", 32'(cfg.rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values of channel 0
        for (int rg = 0; rg < 4; rg++) rd_expect("rst_read_ch0", rg, 0);

        // Non-existent channel on the 3-channel instance
        acc3(1'b1, 13, 'h55);
        acc3(1'b0, 13, 0);
        check("badch_rvalid", 32'(cfg3.rvalid), 32'd1);
        check("badch_rdata", 32'(cfg3.rdata), 32'd0);
        acc3(1'b1, 9, 'h55);
        acc3(1'b0, 9, 0);
        check("ch2_load_3ch", 32'(cfg3.rdata), 32'h55);
        step();
        check("rdata_hold", 32'(cfg3.rdata), 32'h55);
        check("rvalid_drop", 32'(cfg3.rvalid), 32'd0);

        // Ch1 up auto-reload, LOAD = 5: period of 6 ticks
        wr(4 * 1 + 1, 5);
        wr(4 * 1 + 0, 'h5);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tc_pulse[1]) n++;
        end
        check("ch1_pulses", 32'(n), 32'd2);
        rd_expect("ch1_status", 4 * 1 + 3, 1);

        // Ch2 down one-shot from 3
        wr(4 * 2 + 1, 3);
        wr(4 * 2 + 2, 3);
        wr(4 * 2 + 0, 'h3);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (tc_pulse[2]) n++;
        end
        check("ch2_pulses", 32'(n), 32'd1);
        rd_expect("ch2_ctrl", 4 * 2 + 0, 'h2);
        rd_expect("ch2_count", 4 * 2 + 2, 0);

        // Ch0 irq, W1C colliding with a terminal event
        wr(4 * 0 + 1, 2);
        wr(4 * 0 + 0, 'hD);
        step(); step(); step();
        check("ch0_irq_set", 32'(irq), 32'd1);
        step(); step();
        wr(4 * 0 + 3, 1);
        check("ch0_w1c_vs_tc_pulse", 32'(tc_pulse[0]), 32'd1);
        check("ch0_w1c_vs_tc_irq", 32'(irq), 32'd1);
        rd_expect("ch0_status_kept", 4 * 0 + 3, 1);
        wr(4 * 0 + 3, 1);
        check("ch0_w1c_clear_irq", 32'(irq), 32'd0);
        wr(4 * 0 + 0, 0);

        // COUNT write on the terminal tick wins
        wr(4 * 0 + 2, 'h3FE);
        wr(4 * 0 + 1, 'h3FF);
        wr(4 * 0 + 0, 'h5);
        step();
        wr(4 * 0 + 2, 'h3FF);
        check("cntwr_no_pulse", 32'(tc_pulse[0]), 32'd0);
        step();
        check("cntwr_next_pulse", 32'(tc_pulse[0]), 32'd1);
        rd_expect("cntwr_wrapped", 4 * 0 + 2, 0);
        wr(4 * 0 + 0, 0);

        // Prescale
        wr(4 * 3 + 1, 1);
        wr(4 * 3 + 0, 'h25);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tc_pulse[3]) n++;
        end
`ifdef PCOUNTER_PRESCALE_EN
        check("psc_pulses", 32'(n), 32'd2);
        rd_expect("psc_ctrl", 4 * 3 + 0, 'h25);
`else
        check("psc_pulses", 32'(n), 32'd6);
        rd_expect("psc_ctrl", 4 * 3 + 0, 'h05);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                idle();
            end else begin
                cfg.enable = 1'b1;
                cfg.rd_wr  = (r < 8);
                cfg.addr   = 4'($urandom_range(0, 15));
                cfg.wdata  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            end
            step();
        end
        idle();

        // Reset in the middle of activity
        wr(4 * 1 + 0, 'h5);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_tc_pulse", 32'(tc_pulse), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_rvalid", 32'(cfg.rvalid), 32'd0);
        check("midrst_rdata", 32'(cfg.rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_expect("midrst_ch1_count", 4 * 1 + 2, 0);
        rd_expect("midrst_ch1_ctrl", 4 * 1 + 0, 0);
        for (int k = 0; k < 4; k++) step();
        check("ch3inst_irq", 32'(irq3), 32'd0);
        check("ch3inst_tc", 32'(tc3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
